minterm_scanner: RTL and testbench

Sequential truth-table extractor: on a start request it drives every input combination onto a small combinational function under test, waits a settle interval, samples the function output, and assembles the resulting minterm mask. It is the read-back counterpart to the team's sum-of-minterms logic blocks. It sits beside those blocks on the lab board or in a bench harness, recovering the implemented function for comparison against its intended minterm list.

---
 rtl/scan_pkg.sv | 18 +
 rtl/scan_settle_timer.sv | 33 +++
 rtl/minterm_scanner.sv | 153 +++++++++++++++
 tb/tb_minterm_scanner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the minterm scanner
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } scan_state_e;

    localparam int unsigned DEF_N_IN   = 3;
    localparam int unsigned DEF_SETTLE = 2;

    function automatic int unsigned mask_width(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// rtl/scan_settle_timer.sv - loadable down-counter timing the per-combination settle interval
module scan_settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Loaded with SETTLE-1, so expiry is seen in the SETTLE-th cycle after load.
    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/minterm_scanner.sv
// rtl/minterm_scanner.sv - sweeps all input combinations and assembles the minterm mask
// Optional stability check is enabled by defining SCAN_STABILITY_EN.
module minterm_scanner
    import scan_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          f_i,
    output logic [N_IN-1:0]               abc_o,
    output logic                          busy,
    output logic                          done,
    output logic [mask_width(N_IN)-1:0]   minterm_mask,
    output logic [N_IN:0]                 ones_cnt,
    output logic                          unstable
);

    localparam int unsigned MW = mask_width(N_IN);
    localparam int unsigned IW = N_IN + 1;

    scan_state_e   state_q;
    logic [IW-1:0] idx_q;
    logic [MW-1:0] acc_q;
    logic [N_IN:0] cnt_acc_q;
    logic          busy_q;
    logic          done_q;
    logic [MW-1:0] mask_q;
    logic [N_IN:0] ones_q;

    logic [MW-1:0] acc_d;
    logic [N_IN:0] cnt_acc_d;
    logic          last_idx;
    logic          tmr_load;
    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_expire;

    always_comb begin
        acc_d                     = acc_q;
        acc_d[idx_q[N_IN-1:0]]    = f_i;
        cnt_acc_d                 = cnt_acc_q + {{N_IN{1'b0}}, f_i};
        last_idx                  = (idx_q == IW'(MW - 1));
        tmr_load                  = ((state_q == IDLE) && start) ||
                                    ((state_q == SAMPLE) && !last_idx);
        tmr_clr                   = (state_q == IDLE);
        tmr_en                    = (state_q == DRIVE);
    end

    scan_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

`ifdef SCAN_STABILITY_EN
    logic cap_q;
    logic unst_acc_q;
    logic unstable_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            cnt_acc_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mask_q    <= '0;
            ones_q    <= '0;
`ifdef SCAN_STABILITY_EN
            cap_q      <= 1'b0;
            unst_acc_q <= 1'b0;
            unstable_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    idx_q     <= '0;
                    acc_q     <= '0;
                    cnt_acc_q <= '0;
`ifdef SCAN_STABILITY_EN
                    cap_q      <= 1'b0;
                    unst_acc_q <= 1'b0;
`endif
                    if (start) begin
                        state_q <= DRIVE;
                        busy_q  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (tmr_expire) begin
                        state_q <= SAMPLE;
`ifdef SCAN_STABILITY_EN
                        cap_q <= f_i;
`endif
                    end
                end
                SAMPLE: begin
                    acc_q     <= acc_d;
                    cnt_acc_q <= cnt_acc_d;
`ifdef SCAN_STABILITY_EN
                    unst_acc_q <= unst_acc_q | (cap_q != f_i);
`endif
                    // Results are published on entry to DONE so they are valid alongside the done pulse.
                    if (last_idx) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        mask_q  <= acc_d;
                        ones_q  <= cnt_acc_d;
`ifdef SCAN_STABILITY_EN
                        unstable_q <= unst_acc_q | (cap_q != f_i);
`endif
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign abc_o        = idx_q[N_IN-1:0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign minterm_mask = mask_q;
    assign ones_cnt     = ones_q;

`ifdef SCAN_STABILITY_EN
    assign unstable = unstable_q;
`else
    assign unstable = 1'b0;
`endif

endmodule

// File: tb/tb_minterm_scanner.sv
// tb/tb_minterm_scanner.sv - self-checking bench for minterm_scanner
module tb_minterm_scanner;

`ifdef SCAN_STABILITY_EN
    localparam bit STAB = 1'b1;
`else
    localparam bit STAB = 1'b0;
`endif

    localparam int SCAN_LEN = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       f_i;
    logic [2:0] abc_o;
    logic       busy;
    logic       done;
    logic [7:0] minterm_mask;
    logic [3:0] ones_cnt;
    logic       unstable;

    logic       start2;
    logic       f2;
    logic [1:0] abc2;
    logic       busy2;
    logic       done2;
    logic [3:0] mask2;
    logic [2:0] ones2;
    logic       unst2;

    int         cyc = 0;
    logic [7:0] tt;
    logic       glitch_en;
    int         glitch_cyc;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] last_mask;
    logic [3:0] last_ones;

    minterm_scanner #(.N_IN(3), .SETTLE(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .f_i          (f_i),
        .abc_o        (abc_o),
        .busy         (busy),
        .done         (done),
        .minterm_mask (minterm_mask),
        .ones_cnt     (ones_cnt),
        .unstable     (unstable)
    );

    minterm_scanner #(.N_IN(2), .SETTLE(1)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start2),
        .f_i          (f2),
        .abc_o        (abc2),
        .busy         (busy2),
        .done         (done2),
        .minterm_mask (mask2),
        .ones_cnt     (ones2),
        .unstable     (unst2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign f_i = tt[abc_o] ^ (glitch_en && (cyc == glitch_cyc));
    assign f2  = abc2[1] ^ abc2[0];

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c = '0;
        for (int i = 0; i < 8; i++) c += {3'b0, v[i]};
        return c;
    endfunction

    function automatic logic [7:0] table_of_expr();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            logic a, b, c;
            a = i[2]; b = i[1]; c = i[0];
            t[i] = (~a & ~b & ~c) | (a & ~b & c) | (a & b & ~c);
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scan on the 3-input instance; ignore_j re-pulses start mid-scan, glitch_g disturbs one combination.
    task automatic scan1(input logic [7:0] table_v, input string tag, input int ignore_j, input int glitch_g);
        int         k;
        int         done_cnt;
        int         done_at;
        logic       abc_ok, hold_ok, busy_ok;
        logic [7:0] mask_at_done;
        logic [3:0] ones_at_done;
        logic       unst_at_done;
        tt = table_v;
        done_cnt = 0; done_at = -1;
        abc_ok = 1'b1; hold_ok = 1'b1; busy_ok = 1'b1;
        mask_at_done = '0; ones_at_done = '0; unst_at_done = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start = 1'b0;
        if (glitch_g >= 0) begin
            glitch_cyc = k + glitch_g * 3 + 1;
            glitch_en  = 1'b1;
        end
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk);
            start = (j == ignore_j);
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at      = j;
                    mask_at_done = minterm_mask;
                    ones_at_done = ones_cnt;
                    unst_at_done = unstable;
                end
            end
            if (j < SCAN_LEN) begin
                if (abc_o !== 3'(j / 3)) abc_ok = 1'b0;
                if (minterm_mask !== last_mask || ones_cnt !== last_ones) hold_ok = 1'b0;
            end
            if (j >= 1 && j <= SCAN_LEN && busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        glitch_en = 1'b0;
        chk({tag, " abc_step"}, 32'(abc_ok), 32'd1);
        chk({tag, " hold_prev"}, 32'(hold_ok), 32'd1);
        chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, " done_at"}, 32'(done_at), 32'(SCAN_LEN));
        chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, " mask"}, 32'(mask_at_done), 32'(table_v));
        chk({tag, " ones"}, 32'(ones_at_done), 32'(popcount(table_v)));
        chk({tag, " unstable"}, 32'(unst_at_done), 32'((glitch_g >= 0) && STAB));
        chk({tag, " idle_after"}, 32'({busy, minterm_mask}), 32'({1'b0, table_v}));
        last_mask = table_v;
        last_ones = popcount(table_v);
    endtask

    initial begin
        int         k;
        int         done_js[$];
        int         d2_at;
        logic [7:0] rt;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        tt = '0; glitch_en = 1'b0; glitch_cyc = -1;
        last_mask = '0; last_ones = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({abc_o, busy, done, minterm_mask, ones_cnt, unstable}), 32'd0);
        chk("reset_outputs2", 32'({abc2, busy2, done2, mask2, ones2, unst2}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        chk("expr_table", 32'(table_of_expr()), 32'h61);
        scan1(table_of_expr(), "expr", -1, -1);
        scan1(8'h00, "const0", -1, -1);
        scan1(8'hFF, "const1", -1, -1);
        scan1(8'h5A, "ignore_start", 9, -1);
        for (int r = 0; r < 4; r++) begin
            rt = 8'($urandom);
            scan1(rt, "random", -1, -1);
        end

        // Held start: two scans separated by a single IDLE cycle.
        tt = 8'($urandom);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        for (int j = 0; j <= 56; j++) begin
            @(negedge clk);
            if (j == 50) start = 1'b0;
            if (done) done_js.push_back(j);
        end
        chk("b2b_done_count", 32'(done_js.size()), 32'd2);
        if (done_js.size() == 2) begin
            chk("b2b_first", 32'(done_js[0]), 32'd24);
            chk("b2b_second", 32'(done_js[1]), 32'd50);
        end
        chk("b2b_mask", 32'({busy, minterm_mask, ones_cnt}), 32'({1'b0, tt, popcount(tt)}));
        last_mask = tt;
        last_ones = popcount(tt);

        // Asynchronous reset in the middle of a scan.
        tt = 8'hC3;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midscan_reset", 32'({abc_o, busy, done, minterm_mask, ones_cnt, unstable}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        last_mask = '0;
        last_ones = '0;
        @(negedge clk);
        scan1(8'hC3, "after_reset", -1, -1);

        scan1(8'h96, "glitch5", -1, 5);

        // Two-input instance, f = A ^ B.
        d2_at = -1;
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (done2 && d2_at < 0) d2_at = j;
        end
        chk("n2_done_at", 32'(d2_at), 32'd8);
        chk("n2_mask", 32'(mask2), 32'h6);
        chk("n2_ones", 32'(ones2), 32'd2);
        chk("n2_idle", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
